// File: rtl/req_arbiter_rr.sv
// +----------------------------------------------------------------------------+
// | req_arbiter_rr : round-robin / fixed-priority arbiter in front of a memory |
// |                  manager; latches the owner's access parameters.           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module req_arbiter_rr #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH_A  = 32,
  parameter int WIDTH_S  = 16,
  parameter int MODE_RR  = 1,
  parameter int MAX_HOLD = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           I_Req,
  input  logic [NUM_CH-1:0]           I_Term,
  input  logic [NUM_CH*WIDTH_A-1:0]   I_Length,
  input  logic [NUM_CH*WIDTH_S-1:0]   I_Stride,
  input  logic [NUM_CH*WIDTH_A-1:0]   I_Base_Addr,
  input  logic                        I_Ack,
  output logic                        O_Req,
  output logic [WIDTH_A-1:0]          O_Length,
  output logic [WIDTH_S-1:0]          O_Stride,
  output logic [WIDTH_A-1:0]          O_Base_Addr,
  output logic [NUM_CH-1:0]           O_Grant,
  output logic                        O_GrantVld,
  output logic [$clog2(NUM_CH)-1:0]   O_GrantNo,
  output logic                        O_Timeout,
  output logic                        O_Busy
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [WIDTH_A-1:0]  length_q, length_d;
  logic [WIDTH_S-1:0]  stride_q, stride_d;
  logic [WIDTH_A-1:0]  base_q, base_d;

  logic [IDX_W-1:0]    w_winner;
  logic                w_term_owner;
  logic                w_hold_last;
  logic                w_timeout;
  logic [NUM_CH-1:0]   w_grant;

  // Iterating from the far end lets the nearest candidate overwrite the rest.
  generate
    if (MODE_RR != 0) begin : g_rr
      always_comb begin
        w_winner = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
          if (I_Req[IDX_W'((int'(ptr_q) + i) % NUM_CH)]) begin
            w_winner = IDX_W'((int'(ptr_q) + i) % NUM_CH);
          end
        end
      end
    end else begin : g_fixed
      always_comb begin
        w_winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (I_Req[IDX_W'(i)]) begin
            w_winner = IDX_W'(i);
          end
        end
      end
    end
  endgenerate

  assign w_term_owner = I_Term[owner_q];
  assign w_hold_last  = (MAX_HOLD > 0) && (hold_q == C_HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    length_d  = length_q;
    stride_d  = stride_q;
    base_d    = base_q;
    w_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|I_Req) begin
          state_d  = ST_REQ;
          owner_d  = w_winner;
          length_d = I_Length[int'(w_winner)*WIDTH_A +: WIDTH_A];
          stride_d = I_Stride[int'(w_winner)*WIDTH_S +: WIDTH_S];
          base_d   = I_Base_Addr[int'(w_winner)*WIDTH_A +: WIDTH_A];
        end
      end
      ST_REQ: begin
        if (w_term_owner) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end else if (I_Ack) begin
          state_d = ST_GRANT;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + 1'b1;
        // Termination takes precedence over a coincident timeout.
        if (w_term_owner) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end else if (w_hold_last) begin
          state_d   = ST_IDLE;
          ptr_d     = owner_q;
          w_timeout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= IDX_W'(NUM_CH - 1);
      hold_q   <= '0;
      length_q <= '0;
      stride_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      length_q <= length_d;
      stride_q <= stride_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    w_grant = '0;
    if (state_q == ST_GRANT) begin
      w_grant[owner_q] = 1'b1;
    end
  end

  assign O_Req       = (state_q == ST_REQ);
  assign O_Grant     = w_grant;
  assign O_GrantVld  = (state_q == ST_GRANT);
  assign O_GrantNo   = (state_q == ST_IDLE) ? '0 : owner_q;
  assign O_Timeout   = w_timeout;
  assign O_Busy      = (state_q != ST_IDLE);
  assign O_Length    = length_q;
  assign O_Stride    = stride_q;
  assign O_Base_Addr = base_q;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter_rr.sv
// Directed bench for req_arbiter_rr: a round-robin instance and a fixed-priority
// instance, both with a hold limit of 8 cycles.
`default_nettype none

module tb_req_arbiter_rr;

  localparam int NCH = 4;
  localparam int WA  = 32;
  localparam int WS  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              fp_en;
  logic              reset_f;
  logic [NCH-1:0]    I_Req, I_Term, term_f;
  logic [NCH*WA-1:0] I_Length, I_Base_Addr;
  logic [NCH*WS-1:0] I_Stride;
  logic              I_Ack;

  logic              O_Req, O_GrantVld, O_Timeout, O_Busy;
  logic [WA-1:0]     O_Length, O_Base_Addr;
  logic [WS-1:0]     O_Stride;
  logic [NCH-1:0]    O_Grant;
  logic [1:0]        O_GrantNo;

  logic              f_Req, f_GrantVld, f_Timeout, f_Busy;
  logic [WA-1:0]     f_Length, f_Base_Addr;
  logic [WS-1:0]     f_Stride;
  logic [NCH-1:0]    f_Grant;
  logic [1:0]        f_GrantNo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;
  assign reset_f = reset | ~fp_en;

  req_arbiter_rr #(.NUM_CH(NCH), .WIDTH_A(WA), .WIDTH_S(WS), .MODE_RR(1), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset), .I_Req(I_Req), .I_Term(I_Term),
    .I_Length(I_Length), .I_Stride(I_Stride), .I_Base_Addr(I_Base_Addr), .I_Ack(I_Ack),
    .O_Req(O_Req), .O_Length(O_Length), .O_Stride(O_Stride), .O_Base_Addr(O_Base_Addr),
    .O_Grant(O_Grant), .O_GrantVld(O_GrantVld), .O_GrantNo(O_GrantNo),
    .O_Timeout(O_Timeout), .O_Busy(O_Busy)
  );

  req_arbiter_rr #(.NUM_CH(NCH), .WIDTH_A(WA), .WIDTH_S(WS), .MODE_RR(0), .MAX_HOLD(8)) dut_fp (
    .clock(clock), .reset(reset_f), .I_Req(I_Req), .I_Term(term_f),
    .I_Length(I_Length), .I_Stride(I_Stride), .I_Base_Addr(I_Base_Addr), .I_Ack(I_Ack),
    .O_Req(f_Req), .O_Length(f_Length), .O_Stride(f_Stride), .O_Base_Addr(f_Base_Addr),
    .O_Grant(f_Grant), .O_GrantVld(f_GrantVld), .O_GrantNo(f_GrantNo),
    .O_Timeout(f_Timeout), .O_Busy(f_Busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_params(input logic [31:0] base_hi);
    for (int k = 0; k < NCH; k++) begin
      I_Length[k*WA +: WA]    = 32'h0000_0100 + k;
      I_Stride[k*WS +: WS]    = 16'h0010 + 16'(k);
      I_Base_Addr[k*WA +: WA] = base_hi | (32'(k) << 8);
    end
  endtask

  // A request and a grant must never be visible together, and grants stay one-hot.
  always @(negedge clock) begin
    chk("excl_rr", {62'd0, O_Req && (|O_Grant), $countones(O_Grant) > 1}, 64'd0);
    chk("excl_fp", {62'd0, f_Req && (|f_Grant), $countones(f_Grant) > 1}, 64'd0);
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1; fp_en = 1'b0;
    I_Req = '0; I_Term = '0; term_f = '0; I_Ack = 1'b0;
    set_params(32'hA000_0000);
    tick(); tick();

    chk("rst_busy",   64'(O_Busy), 64'd0);
    chk("rst_req",    64'(O_Req), 64'd0);
    chk("rst_grant",  64'(O_Grant), 64'd0);
    chk("rst_no",     64'(O_GrantNo), 64'd0);
    chk("rst_len",    64'(O_Length), 64'd0);
    chk("rst_base",   64'(O_Base_Addr), 64'd0);
    chk("rst_to",     64'(O_Timeout), 64'd0);

    // First arbitration after reset: ptr=3, search starts at 0 -> channel 1
    reset = 1'b0; I_Req = 4'b1010;
    tick();
    chk("a_req",      64'(O_Req), 64'd1);
    chk("a_grant0",   64'(O_Grant), 64'd0);
    chk("a_no",       64'(O_GrantNo), 64'd1);
    chk("a_len",      64'(O_Length), 64'h101);
    I_Ack = 1'b1;
    tick();
    I_Ack = 1'b0;
    chk("a_req_off",  64'(O_Req), 64'd0);
    chk("a_grant",    64'(O_Grant), 64'b0010);
    chk("a_vld",      64'(O_GrantVld), 64'd1);
    chk("a_stride",   64'(O_Stride), 64'h11);
    chk("a_base",     64'(O_Base_Addr), 64'hA000_0100);
    I_Term = 4'b0010; I_Req = '0;
    tick();
    I_Term = '0;
    chk("a_idle",     64'(O_Busy), 64'd0);
    chk("a_idle_g",   64'(O_Grant), 64'd0);
    chk("a_idle_no",  64'(O_GrantNo), 64'd0);
    chk("a_idle_len", 64'(O_Length), 64'h101);

    // Owner 2: foreign term, dropped request and new inputs are ignored
    I_Req = 4'b0100;
    tick();
    chk("b_no",       64'(O_GrantNo), 64'd2);
    chk("b_base",     64'(O_Base_Addr), 64'hA000_0200);
    set_params(32'hDEAD_0000); I_Req = '0; I_Term = 4'b0010;
    tick();
    chk("b_req_hold", 64'(O_Req), 64'd1);
    chk("b_no_hold",  64'(O_GrantNo), 64'd2);
    chk("b_base_hold",64'(O_Base_Addr), 64'hA000_0200);
    I_Term = 4'b0100;
    tick();
    I_Term = '0;
    chk("b_abort",    64'(O_Busy), 64'd0);
    chk("b_abort_req",64'(O_Req), 64'd0);
    chk("b_base_keep",64'(O_Base_Addr), 64'hA000_0200);
    set_params(32'hA000_0000);

    // Re-grant channel 2, then reset in GRANT
    I_Req = 4'b0100;
    tick();
    chk("c_no",       64'(O_GrantNo), 64'd2);
    I_Ack = 1'b1;
    tick();
    I_Ack = 1'b0; I_Term = 4'b0010;
    tick();
    I_Term = '0;
    chk("c_grant",    64'(O_Grant), 64'b0100);
    reset = 1'b1;
    tick();
    chk("r_grant",    64'(O_Grant), 64'd0);
    chk("r_vld",      64'(O_GrantVld), 64'd0);
    chk("r_req",      64'(O_Req), 64'd0);
    chk("r_busy",     64'(O_Busy), 64'd0);
    chk("r_len",      64'(O_Length), 64'd0);
    chk("r_stride",   64'(O_Stride), 64'd0);
    chk("r_base",     64'(O_Base_Addr), 64'd0);
    chk("r_no",       64'(O_GrantNo), 64'd0);

    // Fairness: all request, each grant held 3 cycles
    reset = 1'b0; fp_en = 1'b1; I_Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_req_no",  64'(O_GrantNo), 64'(order[k]));
      chk("rr_req",     64'(O_Req), 64'd1);
      chk("fp_req_no",  64'(f_GrantNo), 64'd0);
      I_Ack = 1'b1;
      tick();
      I_Ack = 1'b0;
      chk("rr_grant",   64'(O_Grant), 64'(4'b0001 << order[k]));
      chk("fp_grant",   64'(f_Grant), 64'b0001);
      tick(); tick();
      I_Term = 4'b0001 << order[k]; term_f = 4'b0001;
      tick();
      I_Term = '0; term_f = '0;
      chk("rr_rel",     64'(O_Busy), 64'd0);
      chk("rr_rel_g",   64'(O_Grant), 64'd0);
    end

    // Timeout: owner 1 never terminates
    tick();
    chk("t_no",       64'(O_GrantNo), 64'd1);
    I_Ack = 1'b1;
    tick();
    I_Ack = 1'b0;
    chk("t_c1",       64'(O_Timeout), 64'd0);
    repeat (6) tick();
    chk("t_c7",       64'(O_Timeout), 64'd0);
    chk("t_c7_vld",   64'(O_GrantVld), 64'd1);
    tick();
    chk("t_c8",       64'(O_Timeout), 64'd1);
    chk("t_c8_grant", 64'(O_Grant), 64'b0010);
    tick();
    chk("t_idle_to",  64'(O_Timeout), 64'd0);
    chk("t_idle",     64'(O_Busy), 64'd0);
    chk("t_idle_vld", 64'(O_GrantVld), 64'd0);
    tick();
    chk("t_next_no",  64'(O_GrantNo), 64'd2);
    chk("t_next_req", 64'(O_Req), 64'd1);

    // Term coinciding with the last hold cycle suppresses the timeout
    I_Ack = 1'b1;
    tick();
    I_Ack = 1'b0;
    repeat (7) tick();
    I_Term = 4'b0100;
    #1;
    chk("tt_to",      64'(O_Timeout), 64'd0);
    chk("tt_grant",   64'(O_Grant), 64'b0100);
    tick();
    I_Term = '0;
    chk("tt_idle",    64'(O_Busy), 64'd0);
    chk("tt_to_idle", 64'(O_Timeout), 64'd0);

    // Ack outside REQ is ignored
    I_Req = '0; I_Ack = 1'b1;
    tick();
    chk("k_idle",     64'(O_Busy), 64'd0);
    I_Req = 4'b0001;
    tick();
    chk("k_req",      64'(O_Req), 64'd1);
    chk("k_no",       64'(O_GrantNo), 64'd0);
    tick();
    chk("k_grant",    64'(O_Grant), 64'b0001);
    I_Ack = 1'b0; I_Req = '0; I_Term = 4'b0001;
    tick();
    I_Term = '0;
    chk("k_end",      64'(O_Busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/req_arbiter_rr.md
REQ_ARBITER_RR -- requirements
Module: req_arbiter_rr

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_CH, 4, requesting lanes (2..16)
- WIDTH_A, 32, length/base-address width
- WIDTH_S, 16, stride width
- MODE_RR, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest)
- MAX_HOLD, 256, grant timeout in cycles (0 = no timeout)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Req  in  NUM_CH  per-channel access request
- I_Term  in  NUM_CH  per-channel end of access
- I_Length  in  NUM_CH*WIDTH_A  lengths; channel k at bits [k*WIDTH_A +: WIDTH_A]
- I_Stride  in  NUM_CH*WIDTH_S  strides; same packing with WIDTH_S
- I_Base_Addr  in  NUM_CH*WIDTH_A  base addresses; same packing as I_Length
- I_Ack  in  1  memory manager accepts the request
- O_Req  out  1  access request to memory manager
- O_Length  out  WIDTH_A  latched length of the owner
- O_Stride  out  WIDTH_S  latched stride of the owner
- O_Base_Addr  out  WIDTH_A  latched base address of the owner
- O_Grant  out  NUM_CH  one-hot grant to the lanes
- O_GrantVld  out  1  a channel is granted
- O_GrantNo  out  $clog2(NUM_CH)  index of the owner
- O_Timeout  out  1  one-cycle pulse on grant timeout
- O_Busy  out  1  state is not IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, REQ, GRANT.
REQ-004 IDLE, any I_Req bit high: select one winner, store its index as the owner, latch its three parameter fields into the output registers, and move to REQ; all on the same edge.
REQ-005 Selection with MODE_RR=1 SHALL pick the first requesting index searching upward from (ptr+1) mod NUM_CH; with MODE_RR=0 it SHALL pick the lowest requesting index.
REQ-006 REQ: O_Req SHALL be 1 and O_Grant all-zero; on I_Ack move to GRANT.
REQ-007 GRANT: O_Grant[owner] SHALL be 1, other O_Grant bits 0, O_GrantVld 1, O_Req 0.
REQ-008 O_GrantNo SHALL equal the owner index in REQ and GRANT, and 0 in IDLE.
REQ-009 O_Length, O_Stride and O_Base_Addr SHALL stay unchanged from the latching edge until the next arbitration, independent of later changes on the inputs.
REQ-010 Only I_Term[owner] SHALL end ownership; I_Term on any other channel and deassertion of I_Req[owner] SHALL be ignored.
REQ-011 I_Term[owner] in REQ (abort) or in GRANT SHALL return the FSM to IDLE on the next edge and set ptr to the owner.
REQ-012 A hold counter SHALL clear on entry to GRANT and increment every GRANT cycle; with MAX_HOLD>0, when the count reaches MAX_HOLD-1 without I_Term[owner], the FSM SHALL return to IDLE, pulse O_Timeout for 1 cycle and set ptr to the owner.
REQ-013 I_Term[owner] and the timeout in the same cycle: I_Term SHALL win, with no O_Timeout pulse.
REQ-014 Every return to IDLE SHALL spend at least one IDLE cycle before the next REQ; outputs in that cycle: O_Grant=0, O_GrantVld=0, O_Req=0.
REQ-015 A channel whose I_Req is still high after release SHALL be treated as a new request and compete normally.
REQ-016 I_Ack outside REQ SHALL be ignored.

Reset
REQ-017 On reset the state SHALL be IDLE, ptr NUM_CH-1, and the hold counter 0.
REQ-018 On reset all outputs, including the latched parameter registers, SHALL be 0.
REQ-019 Reset SHALL override all other inputs in the same cycle, including during REQ or GRANT.

Verification
REQ-020 Reset, then I_Req=4'b1010, I_Ack high one cycle later -> REQ with O_GrantNo=1 and O_Req=1 for 1 cycle, then O_Grant=4'b0010 and O_Length = channel-1 length.
REQ-021 RR fairness: I_Req=4'b1111 held, each grant ended by I_Term after 3 cycles -> grant order 0,1,2,3,0.
REQ-022 MODE_RR=0, same stimulus -> channel 0 is granted every time.
REQ-023 MAX_HOLD=8, owner never terminates -> O_Timeout pulses in GRANT cycle 8, then IDLE and the next channel is granted.
REQ-024 Owner 2: I_Term[1] -> no effect; inputs change -> O_Base_Addr unchanged; I_Term[2] during REQ -> IDLE, and O_Req never overlaps any O_Grant bit.
REQ-025 Reset asserted in GRANT -> every output is 0 on the next cycle, and the next grant starts from channel 0.
